// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared debounce state encodings and cycle defaults
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_ARM     = 2'd1,
    DB_PRESSED = 2'd2,
    DB_DISARM  = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_SYN = 1_000_000;
  localparam int DB_CYCLES_SIM = 16;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - single-bit synchroniser, stability counter and debounce FSM
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_SYN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_press_nxt
);

  localparam int CW = $clog2(DB_CYCLES);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  db_state_t     r_state;
  logic          w_s;
  logic          w_last;

  assign w_s    = r_sync[1];
  assign w_last = (r_cnt == CW'(DB_CYCLES - 1));
  // Exposed so the parent can register any_press on the same edge as o_press.
  assign o_press_nxt = (r_state == DB_ARM) && w_s && w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b00;
      r_cnt     <= '0;
      r_state   <= DB_IDLE;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (r_state)
        // The cycle that leaves IDLE/PRESSED already counts as the first stable one.
        DB_IDLE: begin
          if (w_s) begin
            r_state <= DB_ARM;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        DB_ARM: begin
          if (!w_s) begin
            r_state <= DB_IDLE;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_state <= DB_PRESSED;
            r_cnt   <= '0;
            o_level <= 1'b1;
            o_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DB_PRESSED: begin
          if (!w_s) begin
            r_state <= DB_DISARM;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        DB_DISARM: begin
          if (w_s) begin
            r_state <= DB_PRESSED;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_state   <= DB_IDLE;
            r_cnt     <= '0;
            o_level   <= 1'b0;
            o_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= DB_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - N-channel button debouncer with level, press/release and any_press outputs
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN     = 2,
  parameter int DB_CYCLES = DB_CYCLES_SYN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] w_press_nxt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_raw      (btn_raw[g]),
      .o_level    (btn_level[g]),
      .o_press    (btn_press[g]),
      .o_release  (btn_release[g]),
      .o_press_nxt(w_press_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |w_press_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       any_press;

  int n_chk  = 0;
  int n_pass = 0;
  int n_press [2];
  int n_rel   [2];
  int n_any;

  btn_debounce #(
    .N_BTN    (2),
    .DB_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, sampling 1 ns after each and tallying pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (btn_press[c])   n_press[c]++;
        if (btn_release[c]) n_rel[c]++;
      end
      if (any_press) n_any++;
    end
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 2; c++) begin
      n_press[c] = 0;
      n_rel[c]   = 0;
    end
    n_any = 0;
  endtask

  initial begin
    clr_counts();
    reset_n = 1'b0;
    btn_raw = 2'b11;
    step(3);
    check("rst_level",   32'(btn_level),   32'h0);
    check("rst_press",   32'(btn_press),   32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_any",     32'(any_press),   32'h0);

    // 1: held 2'b11 out of reset
    reset_n = 1'b1;
    step(17);
    check("t1_level_e17", 32'(btn_level), 32'h0);
    step(1);
    check("t1_level_e18", 32'(btn_level), 32'h3);
    check("t1_press_e18", 32'(btn_press), 32'h3);
    check("t1_any_e18",   32'(any_press), 32'h1);
    step(1);
    check("t1_press_e19", 32'(btn_press), 32'h0);
    check("t1_any_e19",   32'(any_press), 32'h0);

    // 2: release bit0, then bounce it
    btn_raw = 2'b10;
    step(17);
    check("t2_rel_e17", 32'(btn_level), 32'h3);
    step(1);
    check("t2_rel_e18",   32'(btn_level),   32'h2);
    check("t2_relpulse",  32'(btn_release), 32'h1);
    step(2);
    clr_counts();
    for (int k = 0; k < 2; k++) begin
      btn_raw[0] = 1'b1; step(5);
      btn_raw[0] = 1'b0; step(5);
    end
    check("t2_bounce_level", 32'(btn_level[0]), 32'h0);
    check("t2_bounce_press", 32'(n_press[0]),   32'h0);
    btn_raw[0] = 1'b1;
    step(17);
    check("t2_level_e17", 32'(btn_level[0]), 32'h0);
    step(1);
    check("t2_level_e18", 32'(btn_level[0]), 32'h1);
    step(5);
    check("t2_one_press", 32'(n_press[0]), 32'h1);

    // 3: 15-cycle glitch on bit1 is absorbed, 16+ cycles releases
    clr_counts();
    btn_raw[1] = 1'b0; step(15);
    btn_raw[1] = 1'b1; step(30);
    check("t3_glitch_level", 32'(btn_level[1]), 32'h1);
    check("t3_glitch_rel",   32'(n_rel[1]),     32'h0);
    btn_raw[1] = 1'b0;
    step(17);
    check("t3_level_e17", 32'(btn_level[1]), 32'h1);
    step(1);
    check("t3_level_e18", 32'(btn_level[1]),   32'h0);
    check("t3_relpulse",  32'(btn_release[1]), 32'h1);
    step(5);
    check("t3_one_rel", 32'(n_rel[1]), 32'h1);

    // 4: independent channels, 3-cycle offset
    btn_raw = 2'b00;
    step(25);
    check("t4_idle_level", 32'(btn_level), 32'h0);
    clr_counts();
    btn_raw[0] = 1'b1; step(3);
    btn_raw[1] = 1'b1; step(14);
    check("t4_press_e17", 32'(btn_press), 32'h0);
    step(1);
    check("t4_press_e18", 32'(btn_press), 32'h1);
    check("t4_any_e18",   32'(any_press), 32'h1);
    step(2);
    check("t4_press_e20", 32'(btn_press), 32'h0);
    step(1);
    check("t4_press_e21", 32'(btn_press), 32'h2);
    check("t4_any_e21",   32'(any_press), 32'h1);
    step(3);
    check("t4_level", 32'(btn_level), 32'h3);
    check("t4_n_any", 32'(n_any),     32'h2);

    // 5: async reset clears a pressed level; reset mid-window restarts the count
    reset_n = 1'b0;
    btn_raw = 2'b00;
    #2;
    check("t5_async_clr", 32'(btn_level), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(3);
    btn_raw = 2'b01;
    step(10);
    reset_n = 1'b0;
    step(3);
    check("t5_in_reset", 32'(btn_level), 32'h0);
    reset_n = 1'b1;
    step(17);
    check("t5_level_e17", 32'(btn_level[0]), 32'h0);
    step(1);
    check("t5_level_e18", 32'(btn_level[0]), 32'h1);

    // 6: a 5-cycle blip on bit1 changes nothing
    clr_counts();
    btn_raw[1] = 1'b1; step(5);
    btn_raw[1] = 1'b0; step(25);
    check("t6_blip_level", 32'(btn_level[1]), 32'h0);
    check("t6_blip_press", 32'(n_press[1]),   32'h0);
    check("t6_blip_any",   32'(n_any),        32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
